// File: rtl/apb3_cmd_master_if.sv
// apb3_cmd_master_if: command handshake, response and APB3 bus signals of the fabric APB initiator.
interface apb3_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PSLVERR, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PSLVERR, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb3_cmd_master.sv
// apb3_cmd_master: turns one accepted command into one APB3 transfer with wait states, PSLVERR and a stall timeout.
module apb3_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input logic               PCLK,
    input logic               PRESERN,
    apb3_cmd_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q, rdata_q;
    logic              rsp_valid_q, err_q, to_q;
    logic              accept, done, abort;

    assign accept = (state_q == IDLE) && bus.cmd_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                state_d = SETUP;
                cnt_d   = '0;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (bus.PREADY) begin
                done    = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
                // A zero TIMEOUT lets the counter wrap harmlessly and never aborts
                if (TIMEOUT != 0 && cnt_d == TO_W'(TIMEOUT)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= state_d != IDLE;
            penable_q   <= state_d == ACCESS;
            rsp_valid_q <= done | abort;
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
            end
            if (done | abort) begin
                rdata_q <= (done && !pwrite_q) ? bus.PRDATA : '0;
                err_q   <= abort | bus.PSLVERR;
                to_q    <= abort;
            end
        end
    end

    // Gated by reset so that every output reads 0 while PRESERN is low
    assign bus.cmd_ready   = PRESERN && (state_q == IDLE);
    assign bus.busy        = state_q != IDLE;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = to_q;
endmodule

// File: tb/tb_apb3_cmd_master.sv
// tb_apb3_cmd_master: vector table plus hand-written sequences; responses scored against a queue of expected results.
module tb_apb3_cmd_master;
    logic PCLK = 1'b0;
    logic PRESERN = 1'b0;

    always #5 PCLK = ~PCLK;

    apb3_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb3_cmd_master #(.ADDR_W(32), .DATA_W(32), .TO_W(8), .TIMEOUT(4)) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .bus     (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=rsp_valid expected=none");
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                chk("rsp_timeout", {31'b0, bus.rsp_timeout}, {31'b0, e.to});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   k;
        logic hold_ok;
        @(negedge PCLK);
        chk("idle_ready", {31'b0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b1;
        bus.PRDATA    = 32'hBAD0BAD0;
        exp_q.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~v.wr;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        chk("setup_sel_en_busy_rdy", {28'b0, bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready}, 32'b1010);
        chk("setup_paddr", bus.PADDR, v.addr);
        k = 0;
        hold_ok = 1'b1;
        while (k < 20) begin
            @(negedge PCLK);
            if (!(bus.PSEL && bus.PENABLE)) break;
            if (bus.PADDR !== v.addr || bus.PWDATA !== v.wdata || bus.PWRITE !== v.wr || bus.cmd_ready !== 1'b0)
                hold_ok = 1'b0;
            bus.PREADY  = (k >= v.waits);
            bus.PSLVERR = bus.PREADY ? v.slverr : 1'b1;
            bus.PRDATA  = bus.PREADY ? v.prdata : 32'hBAD0BAD0;
            k++;
        end
        bus.PREADY = 1'b0;
        chk("access_cycles", k, v.exp_acc);
        chk("access_hold", {31'b0, hold_ok}, 32'd1);
        chk("rsp_cycle_state", {27'b0, bus.rsp_valid, bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready}, 32'b10001);
        @(negedge PCLK);
        chk("rsp_single_pulse", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rsp_rdata_hold", bus.rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h40050000, 32'h000003E8, 0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h40050004, 32'h0,        2,  32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 32'h40050008, 32'h0,        0,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h4005000C, 32'h0,        99, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 4};
        vecs[4] = '{1'b0, 32'h40050010, 32'h0,        3,  32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 4};
        vecs[5] = '{1'b1, 32'h40050014, 32'hCAFEF00D, 1,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 1'b0, 2};
        vecs[6] = '{1'b1, 32'h40050018, 32'h55AA55AA, 99, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 4};
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;
        repeat (3) @(negedge PCLK);
        chk("reset_ctrl", {26'b0, bus.cmd_ready, bus.rsp_valid, bus.PSEL, bus.PENABLE, bus.busy, bus.rsp_err}, 32'd0);
        chk("reset_paddr", bus.PADDR, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        PRESERN = 1'b1;
        #1;
        chk("release_ready", {31'b0, bus.cmd_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: valid held high, cmd_addr toggles while busy
        @(negedge PCLK);
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h11110000;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h00000100;
        bus.cmd_wdata = 32'h00000001;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        @(negedge PCLK);
        chk("b2b_setup1", {29'b0, bus.PSEL, bus.PENABLE, bus.cmd_ready}, 32'b100);
        chk("b2b_paddr1_setup", bus.PADDR, 32'h00000100);
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'hFFFF0000;
        @(negedge PCLK);
        chk("b2b_access1", {29'b0, bus.PSEL, bus.PENABLE, bus.cmd_ready}, 32'b110);
        chk("b2b_paddr1_access", bus.PADDR, 32'h00000100);
        bus.cmd_addr  = 32'h0000FFFF;
        @(negedge PCLK);
        chk("b2b_rsp1", {29'b0, bus.rsp_valid, bus.PSEL, bus.cmd_ready}, 32'b101);
        bus.cmd_addr  = 32'h00000200;
        exp_q.push_back('{32'h11110000, 1'b0, 1'b0});
        @(negedge PCLK);
        chk("b2b_setup2", {29'b0, bus.PSEL, bus.PENABLE, bus.cmd_ready}, 32'b100);
        chk("b2b_paddr2_setup", bus.PADDR, 32'h00000200);
        chk("b2b_pwrite2", {31'b0, bus.PWRITE}, 32'd0);
        bus.cmd_addr  = 32'hFFFF0000;
        @(negedge PCLK);
        chk("b2b_access2", {29'b0, bus.PSEL, bus.PENABLE, bus.cmd_ready}, 32'b110);
        chk("b2b_paddr2_access", bus.PADDR, 32'h00000200);
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("b2b_rsp2", {30'b0, bus.rsp_valid, bus.PSEL}, 32'b10);
        bus.PREADY = 1'b0;

        // Reset while stalled in ACCESS: bus drops at once, no response
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h40050020;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("rst_mid_in_access", {30'b0, bus.PSEL, bus.PENABLE}, 32'b11);
        #2;
        PRESERN = 1'b0;
        #1;
        chk("rst_mid_bus_drop", {29'b0, bus.PSEL, bus.PENABLE, bus.busy}, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, bus.cmd_ready}, 32'd1);
        run_vec(vecs[1]);

        repeat (2) @(negedge PCLK);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
